fpu_control_apply: RTL and testbench

Downstream consumer of the FPU control-word I/O register. It takes the written control word and its one-cycle write strobe and buffers the word while the FPU core is busy. It commits the word to the core at an instruction boundary and decodes the rounding, precision and mask fields. It also raises the FPU interrupt request when unmasked exception flags are pending, emulating 8087 INT behaviour.

---
 rtl/fpu_control_apply.sv | 67 ++++++
 tb/tb_fpu_control_apply.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fpu_control_apply.sv
// fpu_control_apply: buffers FPU control-word writes until the core is idle, decodes the fields and raises the 8087-style interrupt.
module fpu_control_apply #(
    parameter logic [15:0] RESET_CW = 16'h037F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] control_word_in,
    input  logic        control_write,
    input  logic        fpu_busy,
    input  logic [5:0]  status_exceptions,
    input  logic        int_ack,
    output logic [15:0] active_control_word,
    output logic [1:0]  rounding_mode,
    output logic [1:0]  precision_mode,
    output logic [5:0]  exception_mask,
    output logic        apply_pulse,
    output logic        write_pending,
    output logic        overrun,
    output logic        fpu_int_req
);
    typedef enum logic {EMPTY, HELD} state_t;
    state_t      state_q, state_d;
    logic [15:0] active_q, active_d, pend_word_q, pend_word_d, cw;
    logic        cond, cond_q, irq_q, irq_d, overrun_q, overrun_d, apply_q, apply_d;
    logic        commit_direct, commit_held;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            active_q    <= RESET_CW;
            pend_word_q <= '0;
            cond_q      <= 1'b0;
            irq_q       <= 1'b0;
            overrun_q   <= 1'b0;
            apply_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            pend_word_q <= pend_word_d;
            cond_q      <= cond;
            irq_q       <= irq_d;
            overrun_q   <= overrun_d;
            apply_q     <= apply_d;
        end
    end
    always_comb begin
        cw            = {3'b000, control_word_in[12:0]};
        commit_direct = (state_q == EMPTY) && control_write && !fpu_busy;
        commit_held   = (state_q == HELD) && !control_write && !fpu_busy;
        // a write while a word is already held replaces it, so the newest word wins
        state_d       = control_write ? ((state_q == HELD || fpu_busy) ? HELD : EMPTY)
                                      : ((state_q == HELD && fpu_busy) ? HELD : EMPTY);
        pend_word_d   = (control_write && (state_q == HELD || fpu_busy)) ? cw : pend_word_q;
        active_d      = commit_direct ? cw : commit_held ? pend_word_q : active_q;
        overrun_d     = overrun_q | ((state_q == HELD) & control_write);
        apply_d       = commit_direct | commit_held;
        cond          = (|(status_exceptions & ~active_q[5:0])) & ~active_q[7];
        irq_d         = (cond & ~cond_q) | (irq_q & cond & ~int_ack);
    end
    assign active_control_word = active_q;
    assign rounding_mode       = active_q[11:10];
    assign precision_mode      = active_q[9:8];
    assign exception_mask      = active_q[5:0];
    assign apply_pulse         = apply_q;
    assign write_pending       = (state_q == HELD);
    assign overrun             = overrun_q;
    assign fpu_int_req         = irq_q;
endmodule

// File: tb/tb_fpu_control_apply.sv
// tb_fpu_control_apply: directed vectors with hand-computed expectations for fpu_control_apply.
module tb_fpu_control_apply;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] control_word_in;
    logic        control_write, fpu_busy, int_ack;
    logic [5:0]  status_exceptions;
    logic [15:0] active_control_word;
    logic [1:0]  rounding_mode, precision_mode;
    logic [5:0]  exception_mask;
    logic        apply_pulse, write_pending, overrun, fpu_int_req;
    int          n_cmp = 0;
    int          n_err = 0;

    fpu_control_apply dut (
        .clk(clk), .reset_n(reset_n),
        .control_word_in(control_word_in), .control_write(control_write),
        .fpu_busy(fpu_busy), .status_exceptions(status_exceptions), .int_ack(int_ack),
        .active_control_word(active_control_word), .rounding_mode(rounding_mode),
        .precision_mode(precision_mode), .exception_mask(exception_mask),
        .apply_pulse(apply_pulse), .write_pending(write_pending),
        .overrun(overrun), .fpu_int_req(fpu_int_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " active"}, active_control_word, 16'h037F);
        check({tag, " rm"}, 16'(rounding_mode), 16'h0);
        check({tag, " pm"}, 16'(precision_mode), 16'h3);
        check({tag, " mask"}, 16'(exception_mask), 16'h3F);
        check({tag, " apply"}, 16'(apply_pulse), 16'h0);
        check({tag, " pending"}, 16'(write_pending), 16'h0);
        check({tag, " overrun"}, 16'(overrun), 16'h0);
        check({tag, " irq"}, 16'(fpu_int_req), 16'h0);
    endtask

    initial begin
        reset_n = 1'b0; control_word_in = '0; control_write = 1'b0;
        fpu_busy = 1'b0; int_ack = 1'b0; status_exceptions = 6'h01;
        tick(); tick();
        check_reset_vals("in_reset");
        reset_n = 1'b1;
        tick(); tick();
        check_reset_vals("idle");

        // direct write
        control_word_in = 16'hFFFF; control_write = 1'b1;
        tick();
        control_write = 1'b0;
        check("direct active", active_control_word, 16'h1FFF);
        check("direct apply", 16'(apply_pulse), 16'h1);
        check("direct rm", 16'(rounding_mode), 16'h3);
        check("direct pending", 16'(write_pending), 16'h0);
        tick();
        check("direct apply once", 16'(apply_pulse), 16'h0);
        check("direct irq masked", 16'(fpu_int_req), 16'h0);
        status_exceptions = 6'h00;

        // back-to-back direct writes
        control_word_in = 16'h0000; control_write = 1'b1;
        tick();
        check("b2b active0", active_control_word, 16'h0000);
        check("b2b apply0", 16'(apply_pulse), 16'h1);
        control_word_in = 16'h037F;
        tick();
        control_write = 1'b0;
        check("b2b active1", active_control_word, 16'h037F);
        check("b2b apply1", 16'(apply_pulse), 16'h1);
        tick();
        check("b2b apply end", 16'(apply_pulse), 16'h0);

        // held writes with overrun
        fpu_busy = 1'b1; control_word_in = 16'h0C3F; control_write = 1'b1;
        tick();
        check("held pending", 16'(write_pending), 16'h1);
        check("held no overrun", 16'(overrun), 16'h0);
        check("held active", active_control_word, 16'h037F);
        control_word_in = 16'h083F;
        tick();
        control_write = 1'b0;
        check("held overrun", 16'(overrun), 16'h1);
        check("held active2", active_control_word, 16'h037F);
        check("held no apply", 16'(apply_pulse), 16'h0);
        tick();
        check("held still busy", active_control_word, 16'h037F);
        fpu_busy = 1'b0;
        tick();
        check("commit active", active_control_word, 16'h083F);
        check("commit apply", 16'(apply_pulse), 16'h1);
        check("commit pending", 16'(write_pending), 16'h0);
        check("commit rm", 16'(rounding_mode), 16'h2);
        check("commit pm", 16'(precision_mode), 16'h0);
        tick();
        check("commit apply once", 16'(apply_pulse), 16'h0);
        check("overrun sticky", 16'(overrun), 16'h1);

        // interrupt unmask
        status_exceptions = 6'h04; control_word_in = 16'h037B; control_write = 1'b1;
        tick();
        control_write = 1'b0;
        check("irq N+1", 16'(fpu_int_req), 16'h0);
        tick();
        check("irq N+2", 16'(fpu_int_req), 16'h1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("irq acked", 16'(fpu_int_req), 16'h0);
        tick(); tick();
        check("irq no reassert", 16'(fpu_int_req), 16'h0);
        status_exceptions = 6'h00;
        tick();
        check("irq cleared flags", 16'(fpu_int_req), 16'h0);
        status_exceptions = 6'h04;
        tick();
        check("irq reassert", 16'(fpu_int_req), 16'h1);
        status_exceptions = 6'h00;
        tick();
        check("irq drop on cond", 16'(fpu_int_req), 16'h0);
        status_exceptions = 6'h04; int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("irq rise beats ack", 16'(fpu_int_req), 16'h1);
        control_word_in = 16'h037F; control_write = 1'b1;
        tick();
        control_write = 1'b0;
        check("irq mask write N+1", 16'(fpu_int_req), 16'h1);
        tick();
        check("irq mask write N+2", 16'(fpu_int_req), 16'h0);

        // IEM blocks interrupt
        control_word_in = 16'h03FB; control_write = 1'b1;
        tick();
        control_write = 1'b0;
        check("iem active", active_control_word, 16'h03FB);
        tick(); tick();
        check("iem no irq", 16'(fpu_int_req), 16'h0);

        // reset while held with irq high
        control_word_in = 16'h037B; control_write = 1'b1;
        tick();
        control_write = 1'b0;
        tick();
        check("pre-reset irq", 16'(fpu_int_req), 16'h1);
        fpu_busy = 1'b1; control_word_in = 16'h0000; control_write = 1'b1;
        tick();
        control_write = 1'b0;
        check("pre-reset pending", 16'(write_pending), 16'h1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        tick();
        reset_n = 1'b1; fpu_busy = 1'b0;
        tick();
        check("post-reset apply", 16'(apply_pulse), 16'h0);
        tick();
        check("post-reset apply2", 16'(apply_pulse), 16'h0);
        check("post-reset active", active_control_word, 16'h037F);
        check("post-reset pending", 16'(write_pending), 16'h0);
        check("post-reset irq", 16'(fpu_int_req), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
